// File: rtl/bw_icache_refill_pkg.sv
// rfBlackWidowPkg: shared I-cache geometry constants and refill FSM state type
package rfBlackWidowPkg;
  localparam int ICACHE_LINE_BYTES = 128;
  localparam int ICACHE_SET_LSB = 7;
  localparam int ICACHE_SET_MSB = 13;
  typedef enum logic [2:0] {IC_IDLE, IC_FETCH, IC_WRITE, IC_ABORT, IC_HOLD} ic_refill_state_t;
endpackage

// File: rtl/bw_icache_refill_if.sv
// bw_icache_refill_if: line-refill read bus between the refill controller and the memory side
interface bw_icache_refill_if #(
  parameter int AWID = 32,
  parameter int BUS_WID = 128
);
  logic cyc;
  logic stb;
  logic ack;
  logic err;
  logic [AWID-1:0] adr;
  logic [BUS_WID-1:0] dat;
  modport master (output cyc, stb, adr, input ack, err, dat);
  modport slave (input cyc, stb, adr, output ack, err, dat);
endinterface

// File: rtl/bw_icache_refill_victim_sel.sv
// bw_ic_victim_sel: first-invalid way, else round-robin with a registered pointer
module bw_ic_victim_sel #(
  parameter int WAYS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WAYS-1:0] valid_set,
  input  logic            advance,
  output logic [1:0]      victim
);
  logic [1:0] rr_q, rr_d;
  always_comb begin
    rr_d = advance ? (rr_q == 2'(WAYS - 1) ? 2'd0 : rr_q + 2'd1) : rr_q;
    victim = rr_q;
    for (int i = WAYS - 1; i >= 0; i--) if (!valid_set[i]) victim = 2'(i);
  end
  always_ff @(posedge clk) rr_q <= rst ? 2'd0 : rr_d;
endmodule

// File: rtl/bw_icache_refill.sv
// bw_icache_refill: I-cache miss refill FSM, bursts one line, then pulses a one-cycle line write
module bw_icache_refill
  import rfBlackWidowPkg::*;
#(
  parameter int AWID = 32,
  parameter int WAYS = 4,
  parameter int BUS_WID = 128,
  parameter int LINE_W = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss,
  input  logic [AWID-1:0]     miss_adr,
  input  logic [WAYS-1:0]     valid_set,
  input  logic                invce,
  input  logic                invline,
  input  logic                invall,
  input  logic [AWID-1:0]     inv_adr,
  bw_icache_refill_if.master  bus,
  output logic                wr,
  output logic [1:0]          way,
  output logic [AWID-1:0]     ip,
  output logic [LINE_W-1:0]   line,
  output logic                busy,
  output logic                fault
);
  localparam int BEATS = LINE_W / BUS_WID;
  localparam int BW = $clog2(BEATS);
  localparam int BYTE_SH = $clog2(BUS_WID / 8);
  ic_refill_state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [AWID-1:0] base_q, base_d;
  logic [1:0] way_q, way_d, victim;
  logic [LINE_W-1:0] line_q, line_d;
  logic poison_q, poison_d, cyc_q, cyc_d, wr_q, wr_d, fault_q, fault_d, busy_q, busy_d;
  logic advance, inv_hit, unused_bits;
  assign advance = (state_q == IC_IDLE) & miss & (&valid_set);
  assign inv_hit = invce & (invall | (invline &
                   (inv_adr[AWID-1:ICACHE_SET_LSB] == base_q[AWID-1:ICACHE_SET_LSB])));
  assign unused_bits = ^{miss_adr[ICACHE_SET_LSB-1:0], inv_adr[ICACHE_SET_LSB-1:0]};
  bw_ic_victim_sel #(.WAYS(WAYS)) u_victim (
    .clk       (clk),
    .rst       (rst),
    .valid_set (valid_set),
    .advance   (advance),
    .victim    (victim)
  );
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    base_d = base_q;
    way_d = way_q;
    line_d = line_q;
    unique case (state_q)
      IC_IDLE: if (miss) begin
        state_d = IC_FETCH;
        base_d = {miss_adr[AWID-1:ICACHE_SET_LSB], {ICACHE_SET_LSB{1'b0}}};
        way_d = victim;
      end
      IC_FETCH: if (bus.err) begin
        state_d = IC_ABORT;
        beat_d = '0;
      end else if (bus.ack) begin
        line_d[beat_q*BUS_WID +: BUS_WID] = bus.dat;
        beat_d = beat_q + BW'(1);
        state_d = beat_q == BW'(BEATS - 1) ? IC_WRITE : IC_FETCH;
      end
      IC_WRITE, IC_ABORT: state_d = IC_HOLD;
      default: state_d = IC_IDLE;
    endcase
    // poison only arms while a refill is in flight and is dropped as we return to IDLE
    poison_d = state_d == IC_IDLE ? 1'b0 : poison_q | ((state_q != IC_IDLE) & inv_hit);
    cyc_d = state_d == IC_FETCH;
    wr_d = (state_q == IC_WRITE) & ~poison_q;
    fault_d = state_q == IC_ABORT;
    busy_d = state_d != IC_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IC_IDLE;
      beat_q <= '0;
      base_q <= '0;
      way_q <= '0;
      line_q <= '0;
      poison_q <= 1'b0;
      cyc_q <= 1'b0;
      wr_q <= 1'b0;
      fault_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      base_q <= base_d;
      way_q <= way_d;
      line_q <= line_d;
      poison_q <= poison_d;
      cyc_q <= cyc_d;
      wr_q <= wr_d;
      fault_q <= fault_d;
      busy_q <= busy_d;
    end
  end
  assign bus.cyc = cyc_q;
  assign bus.stb = cyc_q;
  assign bus.adr = base_q + (AWID'(beat_q) << BYTE_SH);
  assign wr = wr_q;
  assign way = way_q;
  assign ip = base_q;
  assign line = line_q;
  assign busy = busy_q;
  assign fault = fault_q;
endmodule

// File: tb/tb_bw_icache_refill.sv
// tb_bw_icache_refill: directed vector table plus error, invalidate and reset sequences
module tb_bw_icache_refill;
  typedef struct {
    logic [31:0] adr;
    logic [3:0]  vset;
    int          waits;
    logic [1:0]  way;
    int          lat;
  } vec_t;
  logic clk = 0, rst = 1, miss = 0, invce = 0, invline = 0, invall = 0;
  logic [31:0] miss_adr = 0, inv_adr = 0, mon_base = 0;
  logic [3:0] valid_set = 0;
  logic wr, busy, fault;
  logic [1:0] way;
  logic [31:0] ip;
  logic [1023:0] line;
  int tick = 0, n_chk = 0, n_bad = 0, n_ack = 0, n_wr = 0, n_fault = 0, adr_bad = 0;
  int mon_beat = 0, wait_n = 0, err_beat = 8;
  vec_t vt[10];
  bw_icache_refill_if #(.AWID(32), .BUS_WID(128)) bus ();
  bw_icache_refill dut (
    .clk(clk), .rst(rst), .miss(miss), .miss_adr(miss_adr), .valid_set(valid_set),
    .invce(invce), .invline(invline), .invall(invall), .inv_adr(inv_adr), .bus(bus),
    .wr(wr), .way(way), .ip(ip), .line(line), .busy(busy), .fault(fault)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] mk(input logic [31:0] a);
    return {~a, a + 32'd1, a ^ 32'hdead_beef, a};
  endfunction
  initial forever begin
    @(posedge clk);
    tick++;
  end
  initial begin
    int wcnt = 0;
    bus.ack = 0;
    bus.err = 0;
    bus.dat = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.ack = 0;
      bus.err = 0;
      if (bus.cyc && bus.stb) begin
        if (wcnt < wait_n) wcnt++;
        else begin
          wcnt = 0;
          if (int'(bus.adr[6:4]) == err_beat) bus.err = 1;
          else begin
            bus.ack = 1;
            bus.dat = mk(bus.adr);
          end
        end
      end else wcnt = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst) mon_beat = 0;
    else if (bus.cyc) begin
      if (bus.adr !== mon_base + 32'(mon_beat * 16)) adr_bad++;
      if (bus.err) mon_beat = 0;
      else if (bus.ack) begin
        mon_beat = (mon_beat + 1) % 8;
        n_ack++;
      end
    end
    if (wr) n_wr++;
    if (fault) n_fault++;
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic chk_line(input string nm, input logic [31:0] b);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s line%0d", nm, i), line[i*128 +: 128], mk(b + 32'(i * 16)));
  endtask
  task automatic wait_ev(output logic ok);
    ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = wr | fault;
    end
  endtask
  task automatic wait_beat(input int b, output logic ok);
    ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = bus.cyc && int'(bus.adr[6:4]) == b;
    end
  endtask
  task automatic wait_idle;
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    @(negedge clk);
  endtask
  task automatic apply(input vec_t v, input string nm);
    int t0, a0, w0;
    logic ok;
    logic [31:0] b;
    b = {v.adr[31:7], 7'b0};
    mon_base = b;
    wait_n = v.waits;
    a0 = n_ack;
    w0 = n_wr;
    miss_adr = v.adr;
    valid_set = v.vset;
    miss = 1;
    t0 = tick;
    wait_ev(ok);
    chk({nm, " wr_seen"}, 128'(wr), 128'(ok));
    chk({nm, " wr"}, 128'(wr), 1);
    chk({nm, " latency"}, 128'(tick - t0), 128'(v.lat));
    chk({nm, " way"}, 128'(way), 128'(v.way));
    chk({nm, " ip"}, 128'(ip), 128'(b));
    chk_line(nm, b);
    miss = 0;
    wait_idle();
    chk({nm, " wr_cycles"}, 128'(n_wr - w0), 1);
    chk({nm, " acks"}, 128'(n_ack - a0), 8);
    chk({nm, " adr_seq"}, 128'(adr_bad), 0);
  endtask
  task automatic inv_seq(input string nm, input logic [31:0] ia, input logic all, input int lat, input int acks);
    int t0, a0, w0;
    logic ok;
    mon_base = 32'h0000_3000;
    wait_n = 0;
    a0 = n_ack;
    w0 = n_wr;
    miss_adr = 32'h0000_3008;
    valid_set = 4'b0000;
    miss = 1;
    t0 = tick;
    wait_beat(5, ok);
    chk({nm, " beat5_reached"}, 128'(bus.cyc), 128'(ok));
    invce = 1;
    invline = !all;
    invall = all;
    inv_adr = ia;
    @(negedge clk);
    invce = 0;
    invline = 0;
    invall = 0;
    wait_ev(ok);
    chk({nm, " wr"}, 128'(wr), 1);
    chk({nm, " latency"}, 128'(tick - t0), 128'(lat));
    chk({nm, " way"}, 128'(way), 0);
    chk_line(nm, 32'h0000_3000);
    miss = 0;
    wait_idle();
    chk({nm, " wr_cycles"}, 128'(n_wr - w0), 1);
    chk({nm, " acks"}, 128'(n_ack - a0), 128'(acks));
    chk({nm, " adr_seq"}, 128'(adr_bad), 0);
  endtask
  initial begin
    int t0, a0, w0, f0;
    logic ok;
    vt[0] = '{32'h0000_1234, 4'b0000, 0, 2'd0, 10};
    vt[1] = '{32'h0000_5678, 4'b0001, 0, 2'd1, 10};
    vt[2] = '{32'h0000_9abc, 4'b1011, 0, 2'd2, 10};
    vt[3] = '{32'h0000_0f00, 4'b0111, 0, 2'd3, 10};
    vt[4] = '{32'h1234_5680, 4'b1111, 0, 2'd0, 10};
    vt[5] = '{32'h2000_0080, 4'b1111, 0, 2'd1, 10};
    vt[6] = '{32'h2000_0100, 4'b1111, 2, 2'd2, 26};
    vt[7] = '{32'h3000_007f, 4'b1111, 0, 2'd3, 10};
    vt[8] = '{32'h4000_0000, 4'b1111, 0, 2'd0, 10};
    vt[9] = '{32'hffff_ffff, 4'b1110, 1, 2'd0, 18};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst cyc", 128'(bus.cyc), 0);
    chk("rst stb", 128'(bus.stb), 0);
    chk("rst adr", 128'(bus.adr), 0);
    chk("rst wr", 128'(wr), 0);
    chk("rst busy", 128'(busy), 0);
    chk("rst fault", 128'(fault), 0);
    chk("rst way", 128'(way), 0);
    chk("rst ip", 128'(ip), 0);
    chk("rst line", line[127:0], 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) apply(vt[i], $sformatf("vec%0d", i));
    mon_base = 32'h8000_0200;
    wait_n = 0;
    err_beat = 3;
    a0 = n_ack;
    w0 = n_wr;
    f0 = n_fault;
    miss_adr = 32'h8000_0234;
    valid_set = 4'b0000;
    miss = 1;
    t0 = tick;
    wait_ev(ok);
    chk("err fault", 128'(fault), 1);
    chk("err no_wr", 128'(wr), 0);
    chk("err cyc_drop", 128'(bus.cyc), 0);
    chk("err latency", 128'(tick - t0), 6);
    err_beat = 8;
    @(negedge clk);
    chk("err fault_width", 128'(fault), 0);
    wait_ev(ok);
    chk("err retry wr", 128'(wr), 1);
    chk("err retry latency", 128'(tick - t0), 17);
    chk("err retry ip", 128'(ip), 128'(32'h8000_0200));
    chk_line("err retry", 32'h8000_0200);
    miss = 0;
    wait_idle();
    chk("err wr_cycles", 128'(n_wr - w0), 1);
    chk("err fault_cycles", 128'(n_fault - f0), 1);
    chk("err acks", 128'(n_ack - a0), 11);
    chk("err adr_seq", 128'(adr_bad), 0);
    inv_seq("inv_line", 32'h0000_3040, 1'b0, 21, 16);
    inv_seq("inv_other", 32'h0000_3080, 1'b0, 10, 8);
    inv_seq("inv_all", 32'h0000_0000, 1'b1, 21, 16);
    mon_base = 32'h0000_7700;
    wait_n = 0;
    miss_adr = 32'h0000_7700;
    valid_set = 4'b1111;
    miss = 1;
    wait_beat(4, ok);
    chk("rst_mid beat4_reached", 128'(bus.cyc), 128'(ok));
    w0 = n_wr;
    rst = 1;
    miss = 0;
    @(negedge clk);
    chk("rst_mid cyc", 128'(bus.cyc), 0);
    chk("rst_mid busy", 128'(busy), 0);
    chk("rst_mid wr", 128'(wr), 0);
    rst = 0;
    @(negedge clk);
    chk("rst_mid no_wr", 128'(n_wr - w0), 0);
    apply('{32'h0000_7710, 4'b1111, 0, 2'd0, 10}, "post_rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
